// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared control/status field positions and fill FSM states
package gpu_pkg;

    localparam int CTRL_START      = 0;
    localparam int CTRL_ABORT      = 1;
    localparam int CTRL_CLEAR_DONE = 2;
    localparam int CTRL_COLOR_LSB  = 8;

    localparam int STAT_BUSY       = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_ABORTED    = 2;
    localparam int STAT_COUNT_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/gpu_fill_engine.sv
// rtl/gpu_fill_engine.sv - fills the whole framebuffer with one colour on a start edge
module gpu_fill_engine
    import gpu_pkg::*;
#(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int PIXEL_W   = 12,
    parameter int FB_ADDR_W = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_aresetn,
    input  logic [31:0]          gpu_control,
    output logic [31:0]          gpu_status,
    output logic                 fb_en,
    output logic                 fb_we,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [PIXEL_W-1:0]   fb_din,
    input  logic                 fb_ready
);

    localparam int NUM = FB_WIDTH * FB_HEIGHT;
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(NUM - 1);

    fill_state_t state, next_state;
    logic        start_q;
    logic        busy, done, aborted;
    logic [15:0] fill_count;
    logic        start_evt, abort, clear_done, accept, last_write;
    logic        unused_ctrl;

    assign start_evt   = gpu_control[CTRL_START] & ~start_q;
    assign abort       = gpu_control[CTRL_ABORT];
    assign clear_done  = gpu_control[CTRL_CLEAR_DONE];
    assign accept      = (state == FILL) & fb_ready;
    assign last_write  = accept & (fb_addr == LAST_ADDR);
    assign unused_ctrl = ^gpu_control;

    // Port strobes decode straight from state so an async reset drops them at once.
    assign fb_en = (state == FILL);
    assign fb_we = (state == FILL);

    assign gpu_status = {fill_count, 13'd0, aborted, done, busy};

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start_evt && !abort) next_state = FILL;
            FILL: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (last_write) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            start_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            fill_count <= 16'd0;
            fb_addr    <= '0;
            fb_din     <= '0;
        end else begin
            start_q <= gpu_control[CTRL_START];
            // Later assignments below override this, so start/abort/done win over clear.
            if (clear_done) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start_evt && !abort) begin
                        fb_din  <= gpu_control[CTRL_COLOR_LSB +: PIXEL_W];
                        fb_addr <= '0;
                        done    <= 1'b0;
                        aborted <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                FILL: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                        done    <= 1'b0;
                    end else if (accept) begin
                        fb_addr <= fb_addr + 1'b1;
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    fill_count <= fill_count + 16'd1;
                    fb_addr    <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
